// File: rtl/seq_alu_exec.sv
// Execution-stage ALU with a valid/ready handshake on both sides.
// Logic/arith/branch ops finish in one cycle; SLL/SRL shift one bit per cycle.
module seq_alu_exec #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_alu_op,
    input  logic             in_branch,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_bcond,
    output logic             out_illegal
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic             left_q, left_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             bcond_q, bcond_d;
    logic             illegal_q, illegal_d;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] dec_result;
    logic             dec_bcond;
    logic             dec_illegal;
    logic             dec_shift;
    logic             dec_left;
    logic [WIDTH-1:0] acc_step;

    assign shamt = in_b[SHW-1:0];
    assign diff  = in_a - in_b;

    // Single-cycle results; shifts only land here directly when shamt is zero.
    always_comb begin
        dec_result  = '0;
        dec_bcond   = 1'b0;
        dec_illegal = 1'b0;
        dec_shift   = 1'b0;
        dec_left    = 1'b0;
        if (in_branch) begin
            case (in_alu_op)
                4'b0000: begin dec_result = diff; dec_bcond = (in_a == in_b); end
                4'b1010: begin dec_result = diff; dec_bcond = (in_a != in_b); end
                4'b1000: begin dec_result = diff; dec_bcond = ($signed(in_a) <  $signed(in_b)); end
                4'b1011: begin dec_result = diff; dec_bcond = ($signed(in_a) >= $signed(in_b)); end
                default: dec_illegal = 1'b1;
            endcase
        end else begin
            case (in_alu_op)
                4'b0000: dec_result = in_a + in_b;
                4'b0001: dec_result = diff;
                4'b0100: dec_result = in_a & in_b;
                4'b0101: dec_result = in_a | in_b;
                4'b1000: dec_result = in_a ^ in_b;
                4'b1010: begin
                    dec_result = in_a;
                    dec_shift  = (shamt != '0);
                    dec_left   = 1'b1;
                end
                4'b1011: begin
                    dec_result = in_a;
                    dec_shift  = (shamt != '0);
                end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    assign acc_step = left_q ? (acc_q << 1) : (acc_q >> 1);

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        left_d    = left_q;
        result_d  = result_q;
        bcond_d   = bcond_q;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (dec_shift) begin
                        state_d = S_SHIFT;
                        acc_d   = in_a;
                        cnt_d   = shamt;
                        left_d  = dec_left;
                    end else begin
                        state_d   = S_DONE;
                        result_d  = dec_result;
                        bcond_d   = dec_bcond;
                        illegal_d = dec_illegal;
                    end
                end
            end
            S_SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    state_d   = S_DONE;
                    result_d  = acc_step;
                    bcond_d   = 1'b0;
                    illegal_d = 1'b0;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            left_q    <= 1'b0;
            result_q  <= '0;
            bcond_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            left_q    <= left_d;
            result_q  <= result_d;
            bcond_q   <= bcond_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_DONE);
    assign out_result  = result_q;
    assign out_bcond   = bcond_q;
    assign out_illegal = illegal_q;

endmodule
